head_ptr_table: RTL and testbench

Bucket head-pointer store: the responder end of the head-table write interface driven by the data-table engines, and the lookup stage that attaches a bucket's current chain-head pointer to each hashed command before it enters the data table. It holds one `{valid, ptr}` entry per hash bucket in a simple dual-port RAM. It accepts engine writes every cycle and serves pipelined lookups with backpressure. A clear sequencer zeroes the table on request.

---
 rtl/head_ptr_table.sv | 240 ++++++++++++++++++++++++
 tb/tb_head_ptr_table.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/head_ptr_table.sv
// Bucket head-pointer table: {valid, ptr} per bucket, engine write port, clear sequencer, lookup pipeline.
// Latency: lookup accepted in cycle t appears on out_* in t+RAM_LATENCY+1 (HEAD_PTR_TABLE_BYPASS_EN adds write forwarding).
// Backpressure: credit-based lookup_ready_o (in-flight + queued < FIFO_DEPTH); engine writes have no backpressure.

// Small registered FIFO; storage is reset so the head reads zero out of reset.
// Latency: one cycle push to out_vld. Backpressure: caller guarantees no push when full.
module hpt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign out_vld = (count_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign pop     = out_vld && out_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (in_vld) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(in_vld) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (in_vld) mem_q[wr_ptr_q] <= in_dat;
        end
    end
endmodule

module head_ptr_table #(
    parameter int BUCKET_WIDTH  = 8,
    parameter int PTR_WIDTH     = 10,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int RAM_LATENCY   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [BUCKET_WIDTH-1:0]  lookup_bucket_i,
    input  logic [PAYLOAD_WIDTH-1:0] lookup_payload_i,
    input  logic                     lookup_valid_i,
    output logic                     lookup_ready_o,
    output logic [BUCKET_WIDTH-1:0]  out_bucket_o,
    output logic [PAYLOAD_WIDTH-1:0] out_payload_o,
    output logic [PTR_WIDTH-1:0]     out_head_ptr_o,
    output logic                     out_head_ptr_val_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    input  logic [BUCKET_WIDTH-1:0]  wr_addr_i,
    input  logic [PTR_WIDTH-1:0]     wr_data_ptr_i,
    input  logic                     wr_data_ptr_val_i,
    input  logic                     wr_en_i,
    input  logic                     clear_ram_run_i,
    output logic                     clear_ram_done_o
);
    localparam int DEPTH      = 1 << BUCKET_WIDTH;
    localparam int FIFO_DEPTH = RAM_LATENCY + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W      = PTR_WIDTH + 1;
    localparam int FIFO_W     = BUCKET_WIDTH + PAYLOAD_WIDTH + ENT_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [BUCKET_WIDTH-1:0] clear_addr_q, clear_addr_d;
    logic                    ram_we;
    logic [BUCKET_WIDTH-1:0] ram_waddr;
    logic [ENT_W-1:0]        ram_wdat, ram_rdat, push_ent;
    logic [ENT_W-1:0]        mem [DEPTH];
    logic [ENT_W-1:0]        ram_rd_q [RAM_LATENCY];
    logic [CNT_W-1:0]        fifo_count, in_flight;
    logic [CNT_W:0]          credit_used;
    logic                    lookup_fire;
    logic [FIFO_W-1:0]       fifo_out_dat;

    logic [RAM_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
    logic [BUCKET_WIDTH-1:0]  pipe_bucket_q [RAM_LATENCY];
    logic [BUCKET_WIDTH-1:0]  pipe_bucket_d [RAM_LATENCY];
    logic [PAYLOAD_WIDTH-1:0] pipe_payload_q [RAM_LATENCY];
    logic [PAYLOAD_WIDTH-1:0] pipe_payload_d [RAM_LATENCY];

    always_comb begin
        state_d          = state_q;
        clear_addr_d     = clear_addr_q;
        clear_ram_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_ram_run_i) begin
                    state_d      = CLEAR;
                    clear_addr_d = '0;
                end
            end
            CLEAR: begin
                // A fresh request restarts the sweep rather than finishing the old one.
                if (clear_ram_run_i) begin
                    clear_addr_d = '0;
                end else if (clear_addr_q == '1) begin
                    clear_ram_done_o = 1'b1;
                    state_d          = IDLE;
                end else begin
                    clear_addr_d = clear_addr_q + BUCKET_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_we    = (state_q == CLEAR) ? 1'b1 : wr_en_i;
        ram_waddr = (state_q == CLEAR) ? clear_addr_q : wr_addr_i;
        ram_wdat  = (state_q == CLEAR) ? '0 : {wr_data_ptr_val_i, wr_data_ptr_i};
    end

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) in_flight = in_flight + CNT_W'(pipe_vld_q[i]);
        credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
    end

    // Credits come from registered counts, so a pop frees its slot one cycle later.
    assign lookup_ready_o = rst_i && (state_q == IDLE) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign lookup_fire    = lookup_valid_i && lookup_ready_o;

    always_comb begin
        pipe_vld_d[0]     = lookup_fire;
        pipe_bucket_d[0]  = lookup_bucket_i;
        pipe_payload_d[0] = lookup_payload_i;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_vld_d[i]     = pipe_vld_q[i-1];
            pipe_bucket_d[i]  = pipe_bucket_q[i-1];
            pipe_payload_d[i] = pipe_payload_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            clear_addr_q <= '0;
            pipe_vld_q   <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pipe_bucket_q[i]  <= '0;
                pipe_payload_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            pipe_vld_q   <= pipe_vld_d;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pipe_bucket_q[i]  <= pipe_bucket_d[i];
                pipe_payload_q[i] <= pipe_payload_d[i];
            end
        end
    end

    // Simple dual-port RAM, read-old-data on a same-cycle collision; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (ram_we) mem[ram_waddr] <= ram_wdat;
        if (lookup_fire) ram_rd_q[0] <= mem[lookup_bucket_i];
        for (int i = 1; i < RAM_LATENCY; i++) ram_rd_q[i] <= ram_rd_q[i-1];
    end

    assign ram_rdat = ram_rd_q[RAM_LATENCY-1];

`ifdef HEAD_PTR_TABLE_BYPASS_EN
    logic [RAM_LATENCY-1:0] fwd_hit_q, fwd_hit_d;
    logic [ENT_W-1:0]       fwd_dat_q [RAM_LATENCY];
    logic [ENT_W-1:0]       fwd_dat_d [RAM_LATENCY];

    // Each stage snoops the write of its own cycle; the final stage is past the read window.
    always_comb begin
        fwd_hit_d[0] = ram_we && (ram_waddr == lookup_bucket_i);
        fwd_dat_d[0] = ram_wdat;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            if (ram_we && (ram_waddr == pipe_bucket_q[i-1])) begin
                fwd_hit_d[i] = 1'b1;
                fwd_dat_d[i] = ram_wdat;
            end else begin
                fwd_hit_d[i] = fwd_hit_q[i-1];
                fwd_dat_d[i] = fwd_dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_hit_q <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) fwd_dat_q[i] <= '0;
        end else begin
            fwd_hit_q <= fwd_hit_d;
            for (int i = 0; i < RAM_LATENCY; i++) fwd_dat_q[i] <= fwd_dat_d[i];
        end
    end

    assign push_ent = fwd_hit_q[RAM_LATENCY-1] ? fwd_dat_q[RAM_LATENCY-1] : ram_rdat;
`else
    assign push_ent = ram_rdat;
`endif

    hpt_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_vld  (pipe_vld_q[RAM_LATENCY-1]),
        .in_dat  ({pipe_bucket_q[RAM_LATENCY-1], pipe_payload_q[RAM_LATENCY-1], push_ent}),
        .out_vld (out_valid_o),
        .out_rdy (out_ready_i),
        .out_dat (fifo_out_dat),
        .count   (fifo_count)
    );

    assign {out_bucket_o, out_payload_o, out_head_ptr_val_o, out_head_ptr_o} = fifo_out_dat;
endmodule

// File: tb/tb_head_ptr_table.sv
// Directed bench for head_ptr_table with a result scoreboard and immediate-assertion checks.
module tb_head_ptr_table;
    localparam int BW = 8, PW = 64, PTRW = 10, RL = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [BW-1:0]   lookup_bucket_i;
    logic [PW-1:0]   lookup_payload_i;
    logic            lookup_valid_i, lookup_ready_o;
    logic [BW-1:0]   out_bucket_o;
    logic [PW-1:0]   out_payload_o;
    logic [PTRW-1:0] out_head_ptr_o;
    logic            out_head_ptr_val_o, out_valid_o, out_ready_i;
    logic [BW-1:0]   wr_addr_i;
    logic [PTRW-1:0] wr_data_ptr_i;
    logic            wr_data_ptr_val_i, wr_en_i;
    logic            clear_ram_run_i, clear_ram_done_o;

    head_ptr_table #(
        .BUCKET_WIDTH(BW), .PTR_WIDTH(PTRW), .PAYLOAD_WIDTH(PW), .RAM_LATENCY(RL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lookup_bucket_i(lookup_bucket_i), .lookup_payload_i(lookup_payload_i),
        .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
        .out_bucket_o(out_bucket_o), .out_payload_o(out_payload_o),
        .out_head_ptr_o(out_head_ptr_o), .out_head_ptr_val_o(out_head_ptr_val_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .wr_addr_i(wr_addr_i), .wr_data_ptr_i(wr_data_ptr_i),
        .wr_data_ptr_val_i(wr_data_ptr_val_i), .wr_en_i(wr_en_i),
        .clear_ram_run_i(clear_ram_run_i), .clear_ram_done_o(clear_ram_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [BW-1:0]   b;
        logic [PW-1:0]   p;
        logic            v;
        logic [PTRW-1:0] ptr;
    } exp_t;

    exp_t        sb[$];
    logic [PTRW:0] model [1 << BW];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 128'(out_valid_o), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("out_bucket",  128'(out_bucket_o),       128'(e.b));
                chk("out_payload", 128'(out_payload_o),      128'(e.p));
                chk("out_val",     128'(out_head_ptr_val_o), 128'(e.v));
                chk("out_ptr",     128'(out_head_ptr_o),     128'(e.ptr));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic issue(input logic [BW-1:0] b, input logic [PW-1:0] p,
                         input logic [PTRW:0] e, output int waits);
        lookup_valid_i = 1'b1;
        lookup_bucket_i = b;
        lookup_payload_i = p;
        waits = 0;
        @(negedge clk_i);
        while (!lookup_ready_o && waits < 400) begin
            waits++;
            @(negedge clk_i);
        end
        if (lookup_ready_o) sb.push_back(exp_t'({b, p, e}));
        else chk("accept_timeout", 128'(lookup_ready_o), 128'(1));
        @(posedge clk_i); #1;
    endtask

    task automatic eng_write(input logic [BW-1:0] a, input logic [PTRW-1:0] ptr, input logic v);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_ptr_i = ptr; wr_data_ptr_val_i = v;
        tick();
        wr_en_i = 1'b0;
        model[a] = {v, ptr};
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, 128'(sb.size()), 128'(0));
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    // Entered one cycle after the cycle carrying the clear pulse.
    task automatic clear_seq(input bit eng_wr);
        int done_k = 0;
        int blocked = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk_i);
            if (!lookup_ready_o) blocked++;
            if (clear_ram_done_o) begin
                done_k = k;
                break;
            end
            @(posedge clk_i); #1;
            wr_en_i = eng_wr && (k == 9);
            wr_addr_i = 8'h05; wr_data_ptr_i = 10'h3FF; wr_data_ptr_val_i = 1'b1;
        end
        @(posedge clk_i); #1;
        wr_en_i = 1'b0;
        chk("clear_done_cycle", 128'(done_k), 128'(256));
        chk("clear_ready_low_cycles", 128'(blocked), 128'(256));
        @(negedge clk_i);
        chk("ready_after_clear", 128'(lookup_ready_o), 128'(1));
        chk("done_single_pulse", 128'(clear_ram_done_o), 128'(0));
        @(posedge clk_i); #1;
        foreach (model[i]) model[i] = '0;
    endtask

    initial begin
        int w, n, tot, dones, vlds;
        logic [PTRW:0] rdw_exp;

        rst_i = 1'b0; lookup_bucket_i = '0; lookup_payload_i = '0; lookup_valid_i = 1'b0;
        out_ready_i = 1'b1; wr_addr_i = '0; wr_data_ptr_i = '0; wr_data_ptr_val_i = 1'b0;
        wr_en_i = 1'b0; clear_ram_run_i = 1'b0;
        foreach (model[i]) model[i] = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_out_valid",   128'(out_valid_o),        128'(0));
        chk("rst_ready",       128'(lookup_ready_o),     128'(0));
        chk("rst_done",        128'(clear_ram_done_o),   128'(0));
        chk("rst_out_bucket",  128'(out_bucket_o),       128'(0));
        chk("rst_out_payload", 128'(out_payload_o),      128'(0));
        chk("rst_out_ptr",     128'(out_head_ptr_o),     128'(0));
        chk("rst_out_val",     128'(out_head_ptr_val_o), 128'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1 chk("ready_after_release", 128'(lookup_ready_o), 128'(1));

        // Initial clear, then an empty bucket reads back {0,0}.
        clear_ram_run_i = 1'b1;
        tick();
        clear_ram_run_i = 1'b0;
        clear_seq(1'b0);
        issue(8'h3A, 64'h1111_0000_0000_003A, model[8'h3A], w);
        lookup_valid_i = 1'b0;
        drain("drain_empty_lookup");

        // Write, then look up two cycles later; verify latency t+RL+1.
        eng_write(8'h05, 10'h1C3, 1'b1);
        tick();
        issue(8'h05, 64'hDEAD_BEEF_0000_0005, model[8'h05], w);
        lookup_valid_i = 1'b0;
        @(negedge clk_i); chk("lat_t1", 128'(out_valid_o), 128'(0));
        @(negedge clk_i); chk("lat_t2", 128'(out_valid_o), 128'(0));
        @(negedge clk_i); chk("lat_t3", 128'(out_valid_o), 128'(1));
        @(posedge clk_i); #1;
        drain("drain_write_lookup");

        // Same-cycle write and lookup of bucket 0x07.
        eng_write(8'h07, 10'h100, 1'b1);
        tick();
`ifdef HEAD_PTR_TABLE_BYPASS_EN
        rdw_exp = {1'b1, 10'h2AA};
`else
        rdw_exp = model[8'h07];
`endif
        wr_en_i = 1'b1; wr_addr_i = 8'h07; wr_data_ptr_i = 10'h2AA; wr_data_ptr_val_i = 1'b1;
        issue(8'h07, 64'h0707_0707_0707_0707, rdw_exp, w);
        wr_en_i = 1'b0; lookup_valid_i = 1'b0;
        model[8'h07] = {1'b1, 10'h2AA};
        chk("rdw_accept_wait", 128'(w), 128'(0));
        drain("drain_rdw");
        issue(8'h07, 64'h0707_0000_0000_0002, model[8'h07], w);
        lookup_valid_i = 1'b0;
        drain("drain_after_rdw");

        // Backpressure: exactly FIFO_DEPTH accepted while stalled.
        eng_write(8'h11, 10'h0F0, 1'b1);
        out_ready_i = 1'b0; n = 0;
        lookup_valid_i = 1'b1; lookup_bucket_i = 8'h10; lookup_payload_i = 64'hB0B0_0000_0000_0010;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (lookup_ready_o) begin
                sb.push_back(exp_t'({lookup_bucket_i, lookup_payload_i, model[lookup_bucket_i]}));
                n++;
            end
            @(posedge clk_i); #1;
            lookup_bucket_i = 8'h10 + 8'(n);
            lookup_payload_i = 64'hB0B0_0000_0000_0010 + 64'(n);
        end
        lookup_valid_i = 1'b0;
        @(negedge clk_i);
        chk("bp_accepted",  128'(n),              128'(RL + 2));
        chk("bp_ready_low", 128'(lookup_ready_o), 128'(0));
        chk("bp_head_hold", 128'(out_bucket_o),   128'(8'h10));
        chk("bp_out_valid", 128'(out_valid_o),    128'(1));
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        drain("drain_backpressure");

        // Full throughput with the sink always ready.
        eng_write(8'h22, 10'h055, 1'b1);
        tot = 0;
        for (int i = 0; i < 6; i++) begin
            issue(8'h20 + 8'(i), 64'hCAFE_0000_0000_0020 + 64'(i), model[8'h20 + 8'(i)], w);
            tot += w;
        end
        lookup_valid_i = 1'b0;
        chk("throughput_stalls", 128'(tot), 128'(0));
        drain("drain_throughput");

        // Clear while three lookups are in flight; engine write during clear is dropped.
        issue(8'h05, 64'h5555_0000_0000_0001, model[8'h05], w);
        issue(8'h07, 64'h5555_0000_0000_0002, model[8'h07], w);
        clear_ram_run_i = 1'b1;
        issue(8'h3A, 64'h5555_0000_0000_0003, model[8'h3A], w);
        clear_ram_run_i = 1'b0;
        lookup_valid_i = 1'b0;
        clear_seq(1'b1);
        drain("drain_inflight_clear");
        issue(8'h05, 64'h5555_0000_0000_0004, model[8'h05], w);
        lookup_valid_i = 1'b0;
        drain("drain_post_clear");

        // Reset in the middle of a clear with results queued.
        out_ready_i = 1'b0;
        issue(8'h05, 64'h7777_0000_0000_0001, model[8'h05], w);
        clear_ram_run_i = 1'b1;
        issue(8'h07, 64'h7777_0000_0000_0002, model[8'h07], w);
        clear_ram_run_i = 1'b0;
        lookup_valid_i = 1'b0;
        repeat (5) tick();
        @(negedge clk_i);
        chk("pre_reset_out_valid", 128'(out_valid_o), 128'(1));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        chk("mid_reset_out_valid", 128'(out_valid_o),      128'(0));
        chk("mid_reset_ready",     128'(lookup_ready_o),   128'(0));
        chk("mid_reset_done",      128'(clear_ram_done_o), 128'(0));
        sb.delete();
        out_ready_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b1;
        #1 chk("ready_after_mid_reset", 128'(lookup_ready_o), 128'(1));
        dones = 0; vlds = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_i);
            if (clear_ram_done_o) dones++;
            if (out_valid_o) vlds++;
        end
        chk("aborted_clear_no_done", 128'(dones), 128'(0));
        chk("flushed_no_output",     128'(vlds),  128'(0));
        @(posedge clk_i); #1;

        clear_ram_run_i = 1'b1;
        tick();
        clear_ram_run_i = 1'b0;
        clear_seq(1'b0);
        issue(8'h05, 64'h9999_0000_0000_0005, model[8'h05], w);
        lookup_valid_i = 1'b0;
        drain("drain_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
